// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the memory-stage state encoding and the
// captured EX/MEM request used while a dcache access is outstanding.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } memstate_t;

    typedef struct packed {
        logic     store;
        logic     ll;
        logic     sc;
        logic     regw;
        regbits_t wsel;
        word_t    addr;
        word_t    wdat;
    } mem_req_t;

    // Links and snoops are tracked per word, so byte offsets are ignored.
    function automatic logic same_word(input word_t a, input word_t b);
        return a[WORD_W-1:2] == b[WORD_W-1:2];
    endfunction
endpackage

// File: rtl/ll_link_reg.sv
// LL/SC reservation: one linked word, set by a completed LL and dropped by a
// completed SC, an own store to the word, or a coherence invalidate of it.
module ll_link_reg
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  set,
    input  word_t set_addr,
    input  logic  sc_done,
    input  logic  st_done,
    input  word_t st_addr,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    input  word_t chk_addr,
    output logic  chk_hit
);
    logic  link_valid;
    word_t link_addr;

    // A set in the same cycle as an invalidate wins: the LL data is fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (sc_done
                     || (st_done && same_word(st_addr, link_addr))
                     || (snoop_inv && same_word(snoop_addr, link_addr))) begin
            link_valid <= 1'b0;
        end
    end

    assign chk_hit = link_valid && same_word(chk_addr, link_addr);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage of one core: consumes EX/MEM, runs the dcache handshake,
// stalls upstream until dhit, resolves LL/SC and registers MEM/WB.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   exmem_valid,
    input  logic                   exmem_dren,
    input  logic                   exmem_dwen,
    input  logic                   exmem_ll,
    input  logic                   exmem_sc,
    input  word_t                  exmem_addr,
    input  word_t                  exmem_wdat,
    input  logic                   exmem_regw,
    input  regbits_t               exmem_wsel,
    input  logic                   exmem_halt,
    input  logic                   dhit,
    input  word_t                  dmemload,
    input  logic                   ccinv,
    input  word_t                  ccsnoopaddr,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output word_t                  dmemaddr,
    output word_t                  dmemstore,
    output logic                   mem_stall,
    output logic                   memwb_valid,
    output logic                   memwb_regw,
    output regbits_t               memwb_wsel,
    output word_t                  memwb_wdat,
    output logic                   memwb_halt,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    memstate_t state, state_n;
    mem_req_t  cap, entry;
    logic      capture, link_hit, is_sc, is_mem;
    logic      ll_done, sc_done, st_done;
    logic      wb_load, wb_regw, wb_halt;
    regbits_t  wb_wsel;
    word_t     wb_wdat;

    // When both enables are set the entry is a store.
    assign is_mem = exmem_dren | exmem_dwen;
    assign is_sc  = exmem_dwen & exmem_sc;

    always_comb begin
        entry       = '0;
        entry.store = exmem_dwen;
        entry.ll    = exmem_ll & ~exmem_dwen;
        entry.sc    = is_sc;
        entry.regw  = exmem_regw;
        entry.wsel  = exmem_wsel;
        entry.addr  = exmem_addr;
        entry.wdat  = exmem_wdat;
    end

    ll_link_reg u_link (
        .clk       (CLK),
        .rst       (RST),
        .set       (ll_done),
        .set_addr  (cap.addr),
        .sc_done   (sc_done),
        .st_done   (st_done),
        .st_addr   (cap.addr),
        .snoop_inv (ccinv),
        .snoop_addr(ccsnoopaddr),
        .chk_addr  (exmem_addr),
        .chk_hit   (link_hit)
    );

    always_comb begin
        state_n   = state;
        mem_stall = 1'b0;
        capture   = 1'b0;
        wb_load   = 1'b0;
        wb_regw   = 1'b0;
        wb_wsel   = exmem_wsel;
        wb_wdat   = exmem_addr;
        wb_halt   = 1'b0;
        ll_done   = 1'b0;
        sc_done   = 1'b0;
        st_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (exmem_valid) begin
                    if (exmem_halt) begin
                        wb_load = 1'b1;
                        wb_regw = exmem_regw;
                        wb_halt = 1'b1;
                        state_n = HALTED;
                    end else if (is_sc && !link_hit) begin
                        // Lost reservation: SC fails locally, cache untouched.
                        wb_load = 1'b1;
                        wb_regw = 1'b1;
                        wb_wdat = '0;
                    end else if (is_mem) begin
                        capture   = 1'b1;
                        mem_stall = 1'b1;
                        state_n   = BUSY;
                    end else begin
                        wb_load = 1'b1;
                        wb_regw = exmem_regw;
                    end
                end
            end
            BUSY: begin
                mem_stall = !dhit;
                wb_wsel   = cap.wsel;
                wb_wdat   = cap.addr;
                if (dhit) begin
                    wb_load = 1'b1;
                    state_n = IDLE;
                    if (!cap.store) begin
                        wb_regw = cap.regw;
                        wb_wdat = dmemload;
                        ll_done = cap.ll;
                    end else if (cap.sc) begin
                        wb_regw = 1'b1;
                        wb_wdat = word_t'(1);
                        sc_done = 1'b1;
                    end else begin
                        st_done = 1'b1;
                    end
                end
            end
            default: state_n = state;
        endcase
    end

    assign dmemREN   = (state == BUSY) && !cap.store;
    assign dmemWEN   = (state == BUSY) && cap.store;
    assign dmemaddr  = (state == BUSY) ? cap.addr : '0;
    assign dmemstore = (state == BUSY && cap.store) ? cap.wdat : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            cap          <= '0;
            memwb_valid  <= 1'b0;
            memwb_regw   <= 1'b0;
            memwb_wsel   <= '0;
            memwb_wdat   <= '0;
            memwb_halt   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state       <= state_n;
            memwb_valid <= wb_load;
            if (capture) cap <= entry;
            if (wb_load) begin
                memwb_regw <= wb_regw;
                memwb_wsel <= wb_wsel;
                memwb_wdat <= wb_wdat;
                memwb_halt <= wb_halt;
            end
            if (mem_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, LL/SC with snoops,
// reset abort, halt and the saturating stall counter (4-bit instance).
module tb_mem_stage_ctrl;
    localparam int SCW = 4;
    localparam int SAT = (1 << SCW) - 1;

    logic CLK = 1'b0;
    logic RST;
    logic exmem_valid, exmem_dren, exmem_dwen, exmem_ll, exmem_sc;
    logic [31:0] exmem_addr, exmem_wdat;
    logic exmem_regw, exmem_halt;
    logic [4:0] exmem_wsel;
    logic dhit, ccinv;
    logic [31:0] dmemload, ccsnoopaddr;
    logic dmemREN, dmemWEN, mem_stall;
    logic [31:0] dmemaddr, dmemstore;
    logic memwb_valid, memwb_regw, memwb_halt;
    logic [4:0] memwb_wsel;
    logic [31:0] memwb_wdat;
    logic [SCW-1:0] stall_cycles;

    mem_stage_ctrl #(.STALL_CNT_W(SCW)) dut (
        .CLK(CLK), .RST(RST),
        .exmem_valid(exmem_valid), .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
        .exmem_ll(exmem_ll), .exmem_sc(exmem_sc), .exmem_addr(exmem_addr),
        .exmem_wdat(exmem_wdat), .exmem_regw(exmem_regw), .exmem_wsel(exmem_wsel),
        .exmem_halt(exmem_halt), .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .memwb_valid(memwb_valid), .memwb_regw(memwb_regw), .memwb_wsel(memwb_wsel),
        .memwb_wdat(memwb_wdat), .memwb_halt(memwb_halt), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int exp_stall = 0;
    int o_nst;
    logic o_ren, o_wen, o_v, o_rw;
    logic [31:0] o_wd, o_addr, o_store;

    task automatic clear_entry();
        exmem_valid = 0; exmem_dren = 0; exmem_dwen = 0; exmem_ll = 0; exmem_sc = 0;
        exmem_addr = 0; exmem_wdat = 0; exmem_regw = 0; exmem_wsel = 0; exmem_halt = 0;
    endtask

    task automatic add_stall(input int n);
        exp_stall = (exp_stall + n > SAT) ? SAT : exp_stall + n;
    endtask

    // Presents one entry in IDLE and runs it to completion; dhit arrives in
    // BUSY cycle hitd (0-based), optionally with a coherence invalidate.
    task automatic mem_op(input logic rd, input logic wr, input logic ll, input logic sc,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] ld,
                          input int hitd, input logic inv, input logic [31:0] inv_a);
        exmem_valid = 1; exmem_dren = rd; exmem_dwen = wr; exmem_ll = ll; exmem_sc = sc;
        exmem_addr = a; exmem_wdat = d; exmem_regw = 1; exmem_wsel = 5'd9;
        o_nst = 0; o_ren = 0; o_wen = 0; o_addr = 0; o_store = 0;
        @(negedge CLK);
        if (mem_stall) begin
            o_nst++;
            @(posedge CLK); #1; clear_entry();
            for (int i = 0; i <= hitd; i++) begin
                o_ren |= dmemREN; o_wen |= dmemWEN;
                if (i == 0) begin o_addr = dmemaddr; o_store = dmemstore; end
                if (i == hitd) begin dhit = 1; dmemload = ld; ccinv = inv; ccsnoopaddr = inv_a; end
                @(negedge CLK); if (mem_stall) o_nst++;
                @(posedge CLK); #1; dhit = 0; ccinv = 0;
            end
        end else begin
            o_ren = dmemREN; o_wen = dmemWEN;
            @(posedge CLK); #1; clear_entry();
        end
        o_v = memwb_valid; o_wd = memwb_wdat; o_rw = memwb_regw;
    endtask

    task automatic idle_snoop(input logic [31:0] a);
        ccinv = 1; ccsnoopaddr = a;
        @(posedge CLK); #1; ccinv = 0;
    endtask

    task automatic test_reset();
        RST = 1; clear_entry(); dhit = 0; dmemload = 0; ccinv = 0; ccsnoopaddr = 0;
        repeat (2) @(posedge CLK); #1;
        tests++; if (dmemREN !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b expected 0", dmemREN); end
        tests++; if (dmemWEN !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", dmemWEN); end
        tests++; if (dmemaddr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h expected 0", dmemaddr); end
        tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
        tests++; if (memwb_valid !== 1'b0) begin fails++; $display("FAIL reset_wbvalid: got %b expected 0", memwb_valid); end
        tests++; if (memwb_halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b expected 0", memwb_halt); end
        tests++; if (stall_cycles !== 4'd0) begin fails++; $display("FAIL reset_stallcnt: got %0d expected 0", stall_cycles); end
        RST = 0; exp_stall = 0;
    endtask

    task automatic test_lw();
        mem_op(1, 0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 2, 0, 0);
        add_stall(3);
        tests++; if (o_nst !== 3) begin fails++; $display("FAIL lw_stalls: got %0d expected 3", o_nst); end
        tests++; if (o_ren !== 1'b1 || o_wen !== 1'b0) begin fails++; $display("FAIL lw_req: got ren=%b wen=%b expected 1/0", o_ren, o_wen); end
        tests++; if (o_addr !== 32'h40) begin fails++; $display("FAIL lw_addr: got %h expected 40", o_addr); end
        tests++; if (o_v !== 1'b1 || o_wd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_wb: got v=%b wdat=%h expected 1/deadbeef", o_v, o_wd); end
        tests++; if (memwb_wsel !== 5'd9 || o_rw !== 1'b1) begin fails++; $display("FAIL lw_wsel: got %0d/%b expected 9/1", memwb_wsel, o_rw); end
        tests++; if (stall_cycles !== SCW'(exp_stall)) begin fails++; $display("FAIL lw_stallcnt: got %0d expected %0d", stall_cycles, exp_stall); end
        @(posedge CLK); #1;
        tests++; if (memwb_valid !== 1'b0) begin fails++; $display("FAIL lw_bubble: got %b expected 0", memwb_valid); end
    endtask

    task automatic test_alu();
        mem_op(0, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
        tests++; if (o_nst !== 0 || o_ren !== 1'b0) begin fails++; $display("FAIL alu_nomem: got stalls=%0d ren=%b expected 0/0", o_nst, o_ren); end
        tests++; if (o_v !== 1'b1 || o_wd !== 32'h1234) begin fails++; $display("FAIL alu_wb: got v=%b wdat=%h expected 1/1234", o_v, o_wd); end
        @(posedge CLK); #1;
        tests++; if (memwb_valid !== 1'b0) begin fails++; $display("FAIL alu_bubble: got %b expected 0", memwb_valid); end
    endtask

    task automatic test_ll_sc();
        mem_op(1, 0, 1, 0, 32'h80, 0, 32'h5555, 0, 0, 0);
        add_stall(1);
        tests++; if (o_nst !== 1 || o_wd !== 32'h5555) begin fails++; $display("FAIL ll_wb: got stalls=%0d wdat=%h expected 1/5555", o_nst, o_wd); end
        mem_op(0, 1, 0, 1, 32'h80, 32'hAA, 0, 0, 0, 0);
        add_stall(1);
        tests++; if (o_wen !== 1'b1 || o_store !== 32'hAA || o_addr !== 32'h80) begin fails++; $display("FAIL sc_req: got wen=%b store=%h addr=%h expected 1/aa/80", o_wen, o_store, o_addr); end
        tests++; if (o_wd !== 32'd1 || o_rw !== 1'b1) begin fails++; $display("FAIL sc_ok: got wdat=%h regw=%b expected 1/1", o_wd, o_rw); end
        mem_op(0, 1, 0, 1, 32'h80, 32'hBB, 0, 0, 0, 0);
        tests++; if (o_wen !== 1'b0 || o_nst !== 0) begin fails++; $display("FAIL sc2_nowen: got wen=%b stalls=%0d expected 0/0", o_wen, o_nst); end
        tests++; if (o_v !== 1'b1 || o_wd !== 32'd0 || o_rw !== 1'b1) begin fails++; $display("FAIL sc2_fail: got v=%b wdat=%h regw=%b expected 1/0/1", o_v, o_wd, o_rw); end
        tests++; if (stall_cycles !== SCW'(exp_stall)) begin fails++; $display("FAIL llsc_stallcnt: got %0d expected %0d", stall_cycles, exp_stall); end
    endtask

    task automatic test_snoop();
        mem_op(1, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        idle_snoop(32'h84);
        mem_op(0, 1, 0, 1, 32'h80, 32'h1, 0, 0, 0, 0);
        add_stall(2);
        tests++; if (o_wd !== 32'd1) begin fails++; $display("FAIL snoop_other_word: got %h expected 1", o_wd); end
        mem_op(1, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        idle_snoop(32'h83);
        mem_op(0, 1, 0, 1, 32'h80, 32'h2, 0, 0, 0, 0);
        add_stall(1);
        tests++; if (o_wd !== 32'd0 || o_wen !== 1'b0) begin fails++; $display("FAIL snoop_clear: got wdat=%h wen=%b expected 0/0", o_wd, o_wen); end
        mem_op(1, 0, 1, 0, 32'h80, 0, 0, 0, 1, 32'h80);
        mem_op(0, 1, 0, 1, 32'h80, 32'h3, 0, 0, 0, 0);
        add_stall(2);
        tests++; if (o_wd !== 32'd1) begin fails++; $display("FAIL ll_beats_inv: got %h expected 1", o_wd); end
        mem_op(1, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        mem_op(0, 1, 0, 0, 32'h80, 32'h4, 0, 0, 0, 0);
        tests++; if (o_wen !== 1'b1 || o_rw !== 1'b0 || o_v !== 1'b1) begin fails++; $display("FAIL sw_wb: got wen=%b regw=%b v=%b expected 1/0/1", o_wen, o_rw, o_v); end
        mem_op(0, 1, 0, 1, 32'h80, 32'h5, 0, 0, 0, 0);
        add_stall(2);
        tests++; if (o_wd !== 32'd0) begin fails++; $display("FAIL sw_clears_link: got %h expected 0", o_wd); end
    endtask

    task automatic test_dual_and_sat();
        mem_op(1, 1, 0, 0, 32'h200, 32'h77, 0, 1, 0, 0);
        add_stall(2);
        tests++; if (o_wen !== 1'b1 || o_ren !== 1'b0 || o_rw !== 1'b0) begin fails++; $display("FAIL dual_store: got wen=%b ren=%b regw=%b expected 1/0/0", o_wen, o_ren, o_rw); end
        tests++; if (o_nst !== 2 || stall_cycles !== SCW'(exp_stall)) begin fails++; $display("FAIL dual_stalls: got %0d/%0d expected 2/%0d", o_nst, stall_cycles, exp_stall); end
        mem_op(1, 0, 0, 0, 32'h300, 0, 32'h9, 5, 0, 0);
        add_stall(6);
        tests++; if (stall_cycles !== SCW'(SAT)) begin fails++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cycles, SAT); end
    endtask

    task automatic test_sw_reset();
        logic wen_seen, v_seen;
        mem_op(1, 0, 1, 0, 32'h100, 0, 0, 0, 0, 0);
        exmem_valid = 1; exmem_dwen = 1; exmem_addr = 32'h100; exmem_wdat = 32'hCAFE;
        @(posedge CLK); #1; clear_entry();
        repeat (3) @(posedge CLK); #1;
        tests++; if (dmemWEN !== 1'b1 || dmemaddr !== 32'h100 || dmemstore !== 32'hCAFE) begin fails++; $display("FAIL sw_busy: got wen=%b addr=%h store=%h expected 1/100/cafe", dmemWEN, dmemaddr, dmemstore); end
        RST = 1;
        @(posedge CLK); #1; RST = 0; exp_stall = 0;
        tests++; if (dmemWEN !== 1'b0 || memwb_valid !== 1'b0 || stall_cycles !== 4'd0) begin fails++; $display("FAIL sw_abort: got wen=%b v=%b cnt=%0d expected 0/0/0", dmemWEN, memwb_valid, stall_cycles); end
        wen_seen = 0; v_seen = 0;
        repeat (5) begin @(posedge CLK); #1; wen_seen |= dmemWEN; v_seen |= memwb_valid; end
        tests++; if (wen_seen !== 1'b0 || v_seen !== 1'b0) begin fails++; $display("FAIL sw_after_abort: got wen=%b v=%b expected 0/0", wen_seen, v_seen); end
        mem_op(0, 1, 0, 1, 32'h100, 32'h6, 0, 0, 0, 0);
        tests++; if (o_wd !== 32'd0 || o_wen !== 1'b0) begin fails++; $display("FAIL reset_clears_link: got wdat=%h wen=%b expected 0/0", o_wd, o_wen); end
    endtask

    task automatic test_halt();
        logic ren_seen, st_seen, v_seen, h_all;
        mem_op(1, 0, 0, 0, 32'h40, 0, 32'h1, 1, 0, 0);
        add_stall(2);
        exmem_valid = 1; exmem_halt = 1;
        @(posedge CLK); #1; clear_entry();
        tests++; if (memwb_halt !== 1'b1 || memwb_valid !== 1'b1) begin fails++; $display("FAIL halt_wb: got halt=%b v=%b expected 1/1", memwb_halt, memwb_valid); end
        exmem_valid = 1; exmem_dren = 1; exmem_addr = 32'h40;
        ren_seen = 0; st_seen = 0; v_seen = 0; h_all = 1;
        repeat (5) begin
            @(posedge CLK); #1;
            ren_seen |= dmemREN; st_seen |= mem_stall; v_seen |= memwb_valid; h_all &= memwb_halt;
        end
        clear_entry();
        tests++; if (ren_seen !== 1'b0 || st_seen !== 1'b0) begin fails++; $display("FAIL halted_ignores: got ren=%b stall=%b expected 0/0", ren_seen, st_seen); end
        tests++; if (v_seen !== 1'b0 || h_all !== 1'b1) begin fails++; $display("FAIL halted_hold: got v=%b halt=%b expected 0/1", v_seen, h_all); end
        tests++; if (stall_cycles !== SCW'(exp_stall)) begin fails++; $display("FAIL halt_stallcnt: got %0d expected %0d", stall_cycles, exp_stall); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu();
        test_ll_sc();
        test_snoop();
        test_dual_and_sat();
        test_sw_reset();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
